// File: rtl/sipo_frame_buffer.sv
// Serial-in/parallel-out frame assembler: gathers DEPTH words of WIDTH bits into one wide frame.
// Optional SIPO_DOUBLE_BUFFER_EN lets the next frame fill while the current one is still held.
//
// state  | meaning
// S_FILL | shift reg accepting words (in_ready=1)
// S_FULL | single buffer: frame held until consumer accepts it (in_ready=0)
// S_PEND | double buffer: completed frame waits in shift reg for the output to free up
module sipo_frame_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 18,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DEPTH*WIDTH-1:0] frame,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [CNT_W-1:0]       word_cnt
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_FULL = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DEPTH*WIDTH-1:0] r_shift;
  logic [DEPTH*WIDTH-1:0] w_shift_nxt;
  logic [DEPTH*WIDTH-1:0] w_shifted;
  logic [DEPTH*WIDTH-1:0] r_frame;
  logic [DEPTH*WIDTH-1:0] w_frame_nxt;
  logic                   r_frame_valid;
  logic                   w_fv_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last;

  // in_ready is purely a decode of the registered state, never of frame_ready
  assign w_in_ready = (r_state == S_FILL);
  assign w_accept   = in_valid & w_in_ready;
  assign w_last     = (r_cnt == CNT_W'(DEPTH - 1));
  assign w_shifted  = {in_data, r_shift[DEPTH*WIDTH-1:WIDTH]};

  assign in_ready    = w_in_ready;
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign word_cnt    = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FILL;
      r_shift       <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_frame       <= w_frame_nxt;
      r_frame_valid <= w_fv_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_frame_nxt = r_frame;
    w_fv_nxt    = r_frame_valid;
    w_cnt_nxt   = r_cnt;
    // flush wins over accept and frame_ready; data registers are left as they are
    if (flush) begin
      w_cnt_nxt   = '0;
      w_fv_nxt    = 1'b0;
      w_state_nxt = S_FILL;
    end else begin
`ifdef SIPO_DOUBLE_BUFFER_EN
      if (frame_ready && r_frame_valid) w_fv_nxt = 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            w_shift_nxt = w_shifted;
            if (w_last) begin
              w_cnt_nxt = '0;
              if (!r_frame_valid || frame_ready) begin
                w_frame_nxt = w_shifted;
                w_fv_nxt    = 1'b1;
              end else begin
                w_state_nxt = S_PEND;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        S_PEND: begin
          if (frame_ready) begin
            w_frame_nxt = r_shift;
            w_fv_nxt    = 1'b1;
            w_state_nxt = S_FILL;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
`else
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            w_shift_nxt = w_shifted;
            if (w_last) begin
              w_frame_nxt = w_shifted;
              w_fv_nxt    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_FULL;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        S_FULL: begin
          if (frame_ready) begin
            w_fv_nxt    = 1'b0;
            w_state_nxt = S_FILL;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
`endif
    end
  end

endmodule
